// File: rtl/css_display_resolver_pkg.sv
// Shared definitions for the CSS display resolver.
//   PROP_ID_W       : width of a CSS property id
//   NUM_DISPLAY_KW  : keyword codes 0..NUM_DISPLAY_KW-1 are legal display values
//   display_kw_e    : display keyword encoding
//   rsv_state_e     : resolver FSM states
package css_display_resolver_pkg;

  localparam int unsigned PROP_ID_W      = 8;
  localparam int unsigned NUM_DISPLAY_KW = 20;

  typedef enum logic [31:0] {
    DISP_INLINE       = 32'd0,
    DISP_BLOCK        = 32'd1,
    DISP_NONE         = 32'd2,
    DISP_FLEX         = 32'd3,
    DISP_GRID         = 32'd4,
    DISP_INLINE_BLOCK = 32'd5,
    DISP_INLINE_FLEX  = 32'd6,
    DISP_INLINE_GRID  = 32'd7,
    DISP_CONTENTS     = 32'd8
  } display_kw_e;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } rsv_state_e;

endpackage

// File: rtl/css_display_resolver_candidate_check.sv
// display_candidate_check: combinational decode of one declaration beat.
//   i_prop_id      : property id of the beat
//   i_is_primitive : value is a plain keyword (not var()/calc())
//   i_value        : keyword code
//   o_candidate    : beat is a usable display declaration
//   o_rejected     : beat targets display but cannot be used
module display_candidate_check
  import css_display_resolver_pkg::*;
#(
  parameter logic [PROP_ID_W-1:0] DISPLAY_PROP_ID = 8'h2A,
  parameter int unsigned          NUM_KW          = NUM_DISPLAY_KW
) (
  input  logic [PROP_ID_W-1:0] i_prop_id,
  input  logic                 i_is_primitive,
  input  logic [31:0]          i_value,
  output logic                 o_candidate,
  output logic                 o_rejected
);

  logic w_is_display;
  logic w_in_range;

  assign w_is_display = (i_prop_id == DISPLAY_PROP_ID);
  // Full 32-bit unsigned compare: high bits set must never alias into range.
  assign w_in_range   = (i_value < 32'(NUM_KW));
  assign o_candidate  = w_is_display & i_is_primitive & w_in_range;
  assign o_rejected   = w_is_display & ~(i_is_primitive & w_in_range);

endmodule

// File: rtl/css_display_resolver.sv
// css_display_resolver: resolves the cascaded `display` value of one element
// from its declaration stream and hands it to the display register.
//   i_clock, i_reset   : clock, synchronous active-high reset
//   i_decl_*           : declaration beat stream (valid/ready, last marks end)
//   o_out_*            : resolved element (valid/ready)
//   o_out_is_default   : no usable declaration seen
//   o_out_decl_count   : beats accepted for the element, saturating at 255
// Optional macro DISPLAY_RESOLVER_STATS_EN adds o_stat_elements and
// o_stat_rejected running counters.
module css_display_resolver
  import css_display_resolver_pkg::*;
#(
  parameter logic [PROP_ID_W-1:0] DISPLAY_PROP_ID = 8'h2A,
  parameter int unsigned          NUM_KW          = NUM_DISPLAY_KW,
  parameter logic [31:0]          DISPLAY_DEFAULT = 32'd0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_decl_valid,
  output logic                 o_decl_ready,
  input  logic [PROP_ID_W-1:0] i_decl_prop_id,
  input  logic                 i_decl_is_primitive,
  input  logic [31:0]          i_decl_value,
  input  logic                 i_decl_important,
  input  logic                 i_decl_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [31:0]          o_out_display,
  output logic                 o_out_is_default,
  output logic [7:0]           o_out_decl_count
`ifdef DISPLAY_RESOLVER_STATS_EN
  ,
  output logic [31:0]          o_stat_elements,
  output logic [31:0]          o_stat_rejected
`endif
);

  rsv_state_e  r_state;
  logic [31:0] r_display;
  logic        r_is_default;
  logic        r_important;
  logic [7:0]  r_count;
  logic        w_candidate;
  logic        w_rejected;
  logic        w_accept;

`ifdef DISPLAY_RESOLVER_STATS_EN
  logic [31:0] r_stat_elements;
  logic [31:0] r_stat_rejected;
`endif

  display_candidate_check #(
    .DISPLAY_PROP_ID (DISPLAY_PROP_ID),
    .NUM_KW          (NUM_KW)
  ) u_check (
    .i_prop_id      (i_decl_prop_id),
    .i_is_primitive (i_decl_is_primitive),
    .i_value        (i_decl_value),
    .o_candidate    (w_candidate),
    .o_rejected     (w_rejected)
  );

  assign w_accept = i_decl_valid & (r_state == ACCUM);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ACCUM;
      r_display    <= DISPLAY_DEFAULT;
      r_is_default <= 1'b1;
      r_important  <= 1'b0;
      r_count      <= 8'd0;
`ifdef DISPLAY_RESOLVER_STATS_EN
      r_stat_elements <= 32'd0;
      r_stat_rejected <= 32'd0;
`endif
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            // Important always wins; normal only lands while nothing important is held.
            if (w_candidate && (i_decl_important || !r_important)) begin
              r_display    <= i_decl_value;
              r_important  <= i_decl_important;
              r_is_default <= 1'b0;
            end
            if (i_decl_last) r_state <= EMIT;
`ifdef DISPLAY_RESOLVER_STATS_EN
            if (w_rejected) r_stat_rejected <= r_stat_rejected + 32'd1;
`endif
          end
        end
        EMIT: begin
          // Clearing here leaves the handoff cycle idle; next element starts after.
          if (i_out_ready) begin
            r_state      <= ACCUM;
            r_display    <= DISPLAY_DEFAULT;
            r_is_default <= 1'b1;
            r_important  <= 1'b0;
            r_count      <= 8'd0;
`ifdef DISPLAY_RESOLVER_STATS_EN
            r_stat_elements <= r_stat_elements + 32'd1;
`endif
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign o_decl_ready     = (r_state == ACCUM);
  assign o_out_valid      = (r_state == EMIT);
  assign o_out_display    = r_display;
  assign o_out_is_default = r_is_default;
  assign o_out_decl_count = r_count;

`ifdef DISPLAY_RESOLVER_STATS_EN
  assign o_stat_elements = r_stat_elements;
  assign o_stat_rejected = r_stat_rejected;
`else
  // Rejected decode only feeds the optional statistics.
  logic w_unused;
  assign w_unused = w_rejected;
`endif

endmodule
